// File: rtl/risc_ctrl_pkg.sv
// Shared encodings for the multicycle RISC control sequencer.
// Contents:
//   - opcode constants (IR[31:26])
//   - state_t   : 4-bit sequencer state
//   - alu_op_t, alu_src_b_t, pc_src_t : datapath select encodings
//   - ctrl_t    : bundle of state-decoded control outputs
//   - opcode_legal() : true for the six implemented opcodes
package risc_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_I_EXEC   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRC_B_REG     = 2'b00,
    SRC_B_FOUR    = 2'b01,
    SRC_B_IMM     = 2'b10,
    SRC_B_IMM_SH2 = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'b00,
    PC_SRC_ALUOUT = 2'b01,
    PC_SRC_JUMP   = 2'b10
  } pc_src_t;

  typedef struct packed {
    logic       ir_write;
    logic       mdr_write;
    logic       ab_write;
    logic       aluout_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;

  function automatic logic opcode_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational output decode for the multicycle sequencer.
// Ports:
//   state     in  : current sequencer state
//   mem_ready in  : memory completes the outstanding request this cycle
//   zero      in  : ALU zero flag (branch resolution)
//   ctrl      out : control outputs; all zero unless the state asserts them
// Only ir_write, pc_write and mdr_write look at mem_ready/zero; everything
// else is a pure function of state.
module ctrl_decode
  import risc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        // PC + 4 is computed while the instruction is read; both the IR
        // and the PC load on the cycle memory answers.
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_SRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut while registers are read.
        ctrl.ab_write     = 1'b1;
        ctrl.aluout_write = 1'b1;
        ctrl.alu_src_b    = SRC_B_IMM_SH2;
        ctrl.alu_op       = ALU_ADD;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        ctrl.alu_src_a    = 1'b1;
        ctrl.alu_src_b    = SRC_B_IMM;
        ctrl.alu_op       = ALU_ADD;
        ctrl.aluout_write = 1'b1;
      end
      S_MEM_RD: begin
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.mdr_write = mem_ready;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a    = 1'b1;
        ctrl.alu_src_b    = SRC_B_REG;
        ctrl.alu_op       = ALU_FUNCT;
        ctrl.aluout_write = 1'b1;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_SRC_ALUOUT;
        ctrl.pc_write  = zero;
      end
      S_JUMP: begin
        ctrl.pc_src   = PC_SRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the 32-bit multicycle RISC datapath.
// Ports:
//   clk, reset (async, active-low)      : clock and reset
//   opcode[5:0], zero, mem_ready        : IR opcode, ALU zero, memory done
//   ir/mdr/ab/aluout_write, pc_write,
//   reg_write                           : register write enables
//   mem_req, mem_we, iord               : memory request, direction, address select
//   alu_src_a, alu_src_b, alu_op, pc_src,
//   reg_dst, mem_to_reg                 : datapath mux selects
//   state[3:0]                          : current state (debug)
//   illegal                             : one-cycle pulse in DECODE on an undefined opcode
//   retired[31:0]                       : retired-instruction count (wraps)
// Memory handshake: mem_req rises on entry to a memory state and, with iord
// and mem_we, stays constant until the cycle mem_ready is 1; that cycle
// completes the access and the sequencer leaves the state on the next edge.
// mem_ready has no effect while mem_req is 0.
module multicycle_control
  import risc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        mdr_write,
  output logic        ab_write,
  output logic        aluout_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  state_t      state_q;
  state_t      state_d;
  ctrl_t       ctrl;
  logic        retire;
  logic [31:0] retired_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_RST;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RST:   state_d = S_FETCH;
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_R_EXEC;
          OP_ADDI:      state_d = S_I_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:    state_d = S_RST;
    endcase
  end

  // Output decode.
  ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (ctrl)
  );

  always_comb begin
    ir_write     = ctrl.ir_write;
    mdr_write    = ctrl.mdr_write;
    ab_write     = ctrl.ab_write;
    aluout_write = ctrl.aluout_write;
    pc_write     = ctrl.pc_write;
    reg_write    = ctrl.reg_write;
    mem_req      = ctrl.mem_req;
    mem_we       = ctrl.mem_we;
    iord         = ctrl.iord;
    alu_src_a    = ctrl.alu_src_a;
    alu_src_b    = ctrl.alu_src_b;
    alu_op       = ctrl.alu_op;
    pc_src       = ctrl.pc_src;
    reg_dst      = ctrl.reg_dst;
    mem_to_reg   = ctrl.mem_to_reg;
    state        = state_q;
    illegal      = (state_q == S_DECODE) && !opcode_legal(opcode);
    retired      = retired_q;
  end

  // An instruction retires on its final cycle: every return to FETCH except
  // the illegal-opcode abort from DECODE and the start-up path out of RST.
  assign retire = (state_d == S_FETCH) && (state_q != S_DECODE) &&
                  (state_q != S_FETCH) && (state_q != S_RST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      retired_q <= '0;
    else if (retire) retired_q <= retired_q + 32'd1;
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
  import risc_ctrl_pkg::*;

  localparam int EW = 56;  // {controls(20), state(4), retired(32)}

  typedef struct packed {
    logic ir, mdr, ab, aluout, pcw, regw, req, we, iord, src_a;
    logic [1:0] src_b, alu_op, pc_src;
    logic reg_dst, m2r, ill;
  } tb_ctrl_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  opcode = 6'h00;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_write, mdr_write, ab_write, aluout_write, pc_write, reg_write;
  logic        mem_req, mem_we, iord, alu_src_a, reg_dst, mem_to_reg, illegal;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic [3:0]  state;
  logic [31:0] retired;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .mdr_write(mdr_write), .ab_write(ab_write),
    .aluout_write(aluout_write), .pc_write(pc_write), .reg_write(reg_write),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .state(state), .illegal(illegal), .retired(retired)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            tests = 0;
  int            failed = 0;
  int            cycle_no = 0;
  logic [19:0]   dut_vec;

  assign dut_vec = {ir_write, mdr_write, ab_write, aluout_write, pc_write, reg_write,
                    mem_req, mem_we, iord, alu_src_a, alu_src_b, alu_op, pc_src,
                    reg_dst, mem_to_reg, illegal};

  // Monitor: one expected entry per clock cycle, checked mid-cycle.
  initial begin
    logic [EW-1:0] exp;
    logic [EW-1:0] got;
    forever begin
      @(negedge clk);
      cycle_no++;
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        got = {dut_vec, state, retired};
        tests++;
        if (got !== exp) begin
          failed++;
          $display("FAIL cycle%0d ctrl/state/retired: got ctrl=%05h state=%0d retired=%08h, want ctrl=%05h state=%0d retired=%08h",
                   cycle_no, got[55:36], got[35:32], got[31:0], exp[55:36], exp[35:32], exp[31:0]);
        end
      end
    end
  end

  // ---------------- reference model + drivers ----------------
  logic [5:0]  cur_op = 6'h00;
  logic [31:0] model_ret = 32'd0;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive inputs just after the edge, record expectation.
  task automatic cyc(input tb_ctrl_t c, input state_t s, input logic mr,
                     input logic z, input logic wrap);
    @(posedge clk); #1;
    opcode    = cur_op;
    mem_ready = mr;
    zero      = z;
    if (wrap) begin
      force dut.retired_q = 32'hFFFF_FFFF;
      release dut.retired_q;
      model_ret = 32'hFFFF_FFFF;
    end
    exp_q.push_back({c, s, model_ret});
  endtask

  task automatic hold_reset(input int n);
    tb_ctrl_t c;
    c = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      reset = 1'b0; mem_ready = rbit(); zero = rbit();
      model_ret = 32'd0;
      exp_q.push_back({c, S_RST, model_ret});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.push_back({c, S_RST, model_ret});
  endtask

  // Fetch phase: wf stalled cycles, then the cycle memory answers.
  task automatic fetch(input logic [5:0] op, input int wf);
    tb_ctrl_t c;
    for (int i = 0; i < wf; i++) begin
      c = '0; c.req = 1'b1; c.src_b = 2'b01;
      cyc(c, S_FETCH, 1'b0, rbit(), 1'b0);
    end
    cur_op = op;
    c = '0; c.req = 1'b1; c.src_b = 2'b01; c.ir = 1'b1; c.pcw = 1'b1;
    cyc(c, S_FETCH, 1'b1, rbit(), 1'b0);
  endtask

  // Whole instruction as the architectural step list for its class.
  task automatic run_instr(input logic [5:0] op, input logic z, input int wf,
                           input int wm, input logic wrap);
    tb_ctrl_t c;
    logic     legal;
    legal = op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    fetch(op, wf);
    c = '0; c.ab = 1'b1; c.aluout = 1'b1; c.src_b = 2'b11; c.ill = !legal;
    cyc(c, S_DECODE, rbit(), rbit(), 1'b0);
    if (legal) begin
      case (op)
        OP_LW, OP_SW: begin
          c = '0; c.src_a = 1'b1; c.src_b = 2'b10; c.aluout = 1'b1;
          cyc(c, S_MEM_ADDR, rbit(), rbit(), 1'b0);
          if (op == OP_LW) begin
            c = '0; c.req = 1'b1; c.iord = 1'b1;
            for (int i = 0; i < wm; i++) cyc(c, S_MEM_RD, 1'b0, rbit(), 1'b0);
            c.mdr = 1'b1;
            cyc(c, S_MEM_RD, 1'b1, rbit(), 1'b0);
            c = '0; c.regw = 1'b1; c.m2r = 1'b1;
            cyc(c, S_MEM_WB, rbit(), rbit(), 1'b0);
          end else begin
            c = '0; c.req = 1'b1; c.we = 1'b1; c.iord = 1'b1;
            for (int i = 0; i < wm; i++) cyc(c, S_MEM_WR, 1'b0, rbit(), 1'b0);
            cyc(c, S_MEM_WR, 1'b1, rbit(), 1'b0);
          end
        end
        OP_R: begin
          c = '0; c.src_a = 1'b1; c.alu_op = 2'b10; c.aluout = 1'b1;
          cyc(c, S_R_EXEC, rbit(), rbit(), 1'b0);
          c = '0; c.regw = 1'b1; c.reg_dst = 1'b1;
          cyc(c, S_R_WB, rbit(), rbit(), 1'b0);
        end
        OP_ADDI: begin
          c = '0; c.src_a = 1'b1; c.src_b = 2'b10; c.aluout = 1'b1;
          cyc(c, S_I_EXEC, rbit(), rbit(), 1'b0);
          c = '0; c.regw = 1'b1;
          cyc(c, S_I_WB, rbit(), rbit(), 1'b0);
        end
        OP_BEQ: begin
          c = '0; c.src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pcw = z;
          cyc(c, S_BRANCH, rbit(), z, 1'b0);
        end
        default: begin  // J
          c = '0; c.pc_src = 2'b10; c.pcw = 1'b1;
          cyc(c, S_JUMP, rbit(), rbit(), wrap);
        end
      endcase
      model_ret = model_ret + 32'd1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tb_ctrl_t   c;
    logic [5:0] ops[8];
    logic [5:0] op;
    int         k;
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, 6'h15, 6'h3F};

    hold_reset(2);
    run_instr(OP_R,    1'b0, 0, 0, 1'b0);
    run_instr(OP_LW,   1'b0, 0, 3, 1'b0);
    run_instr(OP_BEQ,  1'b1, 0, 0, 1'b0);
    run_instr(OP_BEQ,  1'b0, 0, 0, 1'b0);
    run_instr(6'h3F,   1'b0, 0, 0, 1'b0);
    run_instr(OP_SW,   1'b0, 1, 2, 1'b0);
    run_instr(OP_ADDI, 1'b0, 2, 0, 1'b0);

    // Store stalled in MEM_WR, then reset lands mid-wait.
    fetch(OP_SW, 0);
    c = '0; c.ab = 1'b1; c.aluout = 1'b1; c.src_b = 2'b11;
    cyc(c, S_DECODE, rbit(), rbit(), 1'b0);
    c = '0; c.src_a = 1'b1; c.src_b = 2'b10; c.aluout = 1'b1;
    cyc(c, S_MEM_ADDR, rbit(), rbit(), 1'b0);
    c = '0; c.req = 1'b1; c.we = 1'b1; c.iord = 1'b1;
    cyc(c, S_MEM_WR, 1'b0, rbit(), 1'b0);
    cyc(c, S_MEM_WR, 1'b0, rbit(), 1'b0);
    hold_reset(2);
    run_instr(OP_R, 1'b0, 0, 0, 1'b0);

    // Counter wrap on a jump.
    run_instr(OP_J, 1'b0, 0, 0, 1'b1);
    run_instr(OP_J, 1'b0, 1, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      k  = $urandom_range(0, 8);
      op = (k == 8) ? 6'($urandom) : ops[k];
      run_instr(op, rbit(), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    repeat (2) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
